// File: rtl/path_store.sv
// Visited/predecessor store with relaxation updates and a
// predecessor-walking path trace streamed over valid/ready.
module path_store #(
  parameter int MAX_NODES   = 15,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
  input  logic                             set_en,
  input  logic                             update_en,
  input  logic [INDEX_WIDTH-1:0]           set_index,
  input  logic [INDEX_WIDTH-1:0]           set_prev,
  output logic [INDEX_WIDTH-1:0]           unvisited_nodes,
  output logic                             all_visited,
  output logic [MAX_NODES-1:0]             visited_vector,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  input  logic                             trace_start,
  input  logic [INDEX_WIDTH-1:0]           trace_dest,
  output logic                             trace_busy,
  output logic                             trace_error,
  output logic                             path_valid,
  input  logic                             path_ready,
  output logic [INDEX_WIDTH-1:0]           path_node,
  output logic                             path_last
);

  localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;
  localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_q, visited_d;
  logic [INDEX_WIDTH-1:0] unvisited_q, unvisited_d;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [INDEX_WIDTH-1:0] steps_q, steps_d;
  logic                   err_q, err_d;

  logic [INDEX_WIDTH-1:0] prev_cur;
  logic [INDEX_WIDTH-1:0] prev_dest;
  logic                   last_cond;
  logic                   in_range;

  assign in_range = set_index < number_of_nodes;

  // Write port: set_en wins over update_en; visited nodes are frozen.
  always_comb begin
    prev_d      = prev_q;
    visited_d   = visited_q;
    unvisited_d = unvisited_q;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (set_index == INDEX_WIDTH'(j) && in_range && !visited_q[j]) begin
        if (set_en) begin
          visited_d[j] = 1'b1;
          prev_d[j]    = set_prev;
          if (unvisited_q != '0) unvisited_d = unvisited_q - ONE;
        end else if (update_en) begin
          prev_d[j] = set_prev;
        end
      end
    end
  end

  always_comb begin
    prev_cur  = UNVISITED;
    prev_dest = UNVISITED;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (cur_q == INDEX_WIDTH'(j))      prev_cur  = prev_q[j];
      if (trace_dest == INDEX_WIDTH'(j)) prev_dest = prev_q[j];
    end
  end

  assign last_cond = (prev_cur == cur_q) || (prev_cur == UNVISITED) ||
                     (steps_q == number_of_nodes - ONE);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    steps_d    = steps_q;
    err_d      = err_q;
    path_valid = 1'b0;
    path_last  = 1'b0;
    path_node  = '0;
    unique case (state_q)
      IDLE: begin
        if (trace_start) begin
          if (trace_dest >= number_of_nodes || prev_dest == UNVISITED) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            cur_d   = trace_dest;
            steps_d = '0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        path_valid = 1'b1;
        path_node  = cur_q;
        path_last  = last_cond;
        if (path_ready) begin
          if (last_cond) begin
            state_d = IDLE;
            if (prev_cur != cur_q) err_d = 1'b1;
          end else begin
            cur_d   = prev_cur;
            steps_d = steps_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < MAX_NODES; j++) prev_q[j] <= UNVISITED;
      visited_q   <= '0;
      unvisited_q <= number_of_nodes;
      state_q     <= IDLE;
      cur_q       <= '0;
      steps_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int j = 0; j < MAX_NODES; j++) prev_q[j] <= prev_d[j];
      visited_q   <= visited_d;
      unvisited_q <= unvisited_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      steps_q     <= steps_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    prev_vector_flattened = '0;
    for (int j = 0; j < MAX_NODES; j++)
      prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] = prev_q[j];
  end

  assign unvisited_nodes = unvisited_q;
  assign all_visited     = (unvisited_q == '0);
  assign visited_vector  = visited_q;
  assign trace_busy      = (state_q != IDLE);
  assign trace_error     = err_q;

endmodule

// File: tb/tb_path_store.sv
// Randomised and directed bench for path_store against a
// behavioural graph/trace model.
module tb_path_store;
  localparam int N = 15;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   number_of_nodes = '0;
  logic           set_en = 1'b0;
  logic           update_en = 1'b0;
  logic [W-1:0]   set_index = '0;
  logic [W-1:0]   set_prev = '0;
  logic [W-1:0]   unvisited_nodes;
  logic           all_visited;
  logic [N-1:0]   visited_vector;
  logic [W*N-1:0] prev_vector_flattened;
  logic           trace_start = 1'b0;
  logic [W-1:0]   trace_dest = '0;
  logic           trace_busy;
  logic           trace_error;
  logic           path_valid;
  logic           path_ready = 1'b0;
  logic [W-1:0]   path_node;
  logic           path_last;

  path_store #(.MAX_NODES(N), .INDEX_WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .number_of_nodes(number_of_nodes),
    .set_en(set_en), .update_en(update_en),
    .set_index(set_index), .set_prev(set_prev),
    .unvisited_nodes(unvisited_nodes), .all_visited(all_visited),
    .visited_vector(visited_vector),
    .prev_vector_flattened(prev_vector_flattened),
    .trace_start(trace_start), .trace_dest(trace_dest),
    .trace_busy(trace_busy), .trace_error(trace_error),
    .path_valid(path_valid), .path_ready(path_ready),
    .path_node(path_node), .path_last(path_last)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int m_prev [16];
  bit m_vis  [16];
  int m_cnt;
  int m_n;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    number_of_nodes = W'(n);
    set_en = 0; update_en = 0; trace_start = 0; path_ready = 0;
    reset = 1;
    step();
    reset = 0;
    m_n = n;
    m_cnt = n;
    for (int i = 0; i < 16; i++) begin
      m_prev[i] = 15;
      m_vis[i] = 0;
    end
  endtask

  task automatic do_write(input bit s, input bit u, input int idx, input int p);
    set_en = s; update_en = u;
    set_index = W'(idx); set_prev = W'(p);
    step();
    set_en = 0; update_en = 0;
    if (idx < m_n && !m_vis[idx]) begin
      if (s) begin
        m_vis[idx] = 1;
        m_prev[idx] = p;
        if (m_cnt > 0) m_cnt--;
      end else if (u) begin
        m_prev[idx] = p;
      end
    end
  endtask

  function automatic logic [W*N-1:0] exp_flat();
    logic [W*N-1:0] f;
    f = '0;
    for (int j = 0; j < N; j++) f[W*j +: W] = W'(m_prev[j]);
    return f;
  endfunction

  function automatic logic [N-1:0] exp_vis();
    logic [N-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j] = m_vis[j];
    return v;
  endfunction

  function automatic bit pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one trace request and checks beats, handshake and error flag.
  task automatic run_trace(input int dest, input int mode, input string tag);
    int exp_q[$];
    int got[$];
    bit exp_err;
    int cur, st, p, cyc;
    bit done, stalled;
    logic [W-1:0] held;
    exp_err = 0;
    if (dest >= m_n || m_prev[dest] == 15) begin
      exp_err = 1;
    end else begin
      cur = dest; st = 0;
      forever begin
        exp_q.push_back(cur);
        p = m_prev[cur];
        if (p == cur || p == 15 || st == m_n - 1) begin
          exp_err = (p != cur);
          break;
        end
        cur = p; st++;
      end
    end
    trace_dest = W'(dest);
    trace_start = 1;
    step();
    trace_start = 0;
    if (exp_q.size() == 0) begin
      checks++;
      if (trace_error !== 1'b1 || trace_busy !== 1'b0 || path_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s reject: err=%b busy=%b valid=%b required err=1 busy=0 valid=0",
                 tag, trace_error, trace_busy, path_valid);
      end
      return;
    end
    cyc = 0; done = 0; stalled = 0; held = '0;
    while (!done && cyc < 200) begin
      path_ready = pat(mode, cyc);
      if (path_valid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL %s valid cyc %0d: got %b required 1", tag, cyc, path_valid);
        break;
      end
      if (stalled) begin
        checks++;
        if (path_node !== held) begin
          errors++;
          $display("FAIL %s hold: node %0d required %0d", tag, path_node, held);
        end
      end
      if (path_ready) begin
        got.push_back(int'(path_node));
        checks++;
        if (path_last !== (got.size() == exp_q.size())) begin
          errors++;
          $display("FAIL %s last beat %0d: got %b required %b",
                   tag, got.size(), path_last, got.size() == exp_q.size());
        end
        if (path_last === 1'b1) done = 1;
        stalled = 0;
      end else begin
        stalled = 1;
        held = path_node;
      end
      step();
      cyc++;
    end
    path_ready = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no last beat after %0d cycles", tag, cyc);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d beats required %0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got %0d required %0d", tag, i, got[i], exp_q[i]);
      end
    end
    if (mode == 0) begin
      checks++;
      if (cyc != exp_q.size()) begin
        errors++;
        $display("FAIL %s rate: %0d cycles required %0d", tag, cyc, exp_q.size());
      end
    end
    checks++;
    if (trace_busy !== 1'b0 || path_valid !== 1'b0 || trace_error !== exp_err) begin
      errors++;
      $display("FAIL %s end: busy=%b valid=%b err=%b required 0 0 %b",
               tag, trace_busy, path_valid, trace_error, exp_err);
    end
  endtask

  task automatic test_reset();
    do_reset(5);
    checks++;
    if (unvisited_nodes !== 4'd5 || all_visited !== 1'b0) begin
      errors++;
      $display("FAIL reset count: cnt=%0d all=%b required 5 0", unvisited_nodes, all_visited);
    end
    checks++;
    if (prev_vector_flattened !== {(W*N){1'b1}} || visited_vector !== '0) begin
      errors++;
      $display("FAIL reset arrays: prev=%h vis=%h required all F and 0",
               prev_vector_flattened, visited_vector);
    end
    checks++;
    if (trace_busy !== 0 || trace_error !== 0 || path_valid !== 0 ||
        path_last !== 0 || path_node !== '0) begin
      errors++;
      $display("FAIL reset trace: busy=%b err=%b valid=%b last=%b node=%0d required zeros",
               trace_busy, trace_error, path_valid, path_last, path_node);
    end
  endtask

  task automatic test_set();
    do_write(1, 0, 0, 0);
    do_write(1, 0, 1, 0);
    do_write(1, 0, 2, 1);
    do_write(1, 0, 3, 2);
    checks++;
    if (unvisited_nodes !== 4'd1 || visited_vector !== 15'h000F) begin
      errors++;
      $display("FAIL set count: cnt=%0d vis=%h required 1 000f", unvisited_nodes, visited_vector);
    end
    do_write(1, 0, 2, 3);
    checks++;
    if (prev_vector_flattened[8 +: 4] !== 4'd1 || unvisited_nodes !== 4'd1) begin
      errors++;
      $display("FAIL reset_visited: prev2=%0d cnt=%0d required 1 1",
               prev_vector_flattened[8 +: 4], unvisited_nodes);
    end
  endtask

  task automatic test_update();
    do_write(0, 1, 4, 3);
    checks++;
    if (prev_vector_flattened[16 +: 4] !== 4'd3 || visited_vector[4] !== 1'b0 ||
        unvisited_nodes !== 4'd1) begin
      errors++;
      $display("FAIL update: prev4=%0d vis4=%b cnt=%0d required 3 0 1",
               prev_vector_flattened[16 +: 4], visited_vector[4], unvisited_nodes);
    end
    do_write(1, 1, 4, 1);
    checks++;
    if (prev_vector_flattened[16 +: 4] !== 4'd1 || unvisited_nodes !== 4'd0 ||
        all_visited !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: prev4=%0d cnt=%0d all=%b required 1 0 1",
               prev_vector_flattened[16 +: 4], unvisited_nodes, all_visited);
    end
    do_write(0, 1, 4, 3);
    do_write(1, 0, 7, 2);
    checks++;
    if (prev_vector_flattened !== exp_flat() || unvisited_nodes !== 4'd0) begin
      errors++;
      $display("FAIL update_visited: prev=%h cnt=%0d required %h 0",
               prev_vector_flattened, unvisited_nodes, exp_flat());
    end
  endtask

  task automatic test_trace();
    run_trace(3, 0, "trace_d3");
    run_trace(3, 1, "trace_stall");
  endtask

  task automatic test_bad_dest();
    do_reset(5);
    do_write(1, 0, 0, 0);
    run_trace(2, 0, "bad_unvisited");
    run_trace(0, 0, "clear_err");
    run_trace(7, 0, "bad_range");
  endtask

  task automatic test_loop();
    do_reset(5);
    do_write(0, 1, 1, 2);
    do_write(0, 1, 2, 1);
    run_trace(1, 0, "loop_guard");
  endtask

  task automatic test_reset_mid();
    do_reset(5);
    do_write(1, 0, 0, 0);
    do_write(1, 0, 1, 0);
    do_write(1, 0, 2, 1);
    trace_dest = 4'd2;
    trace_start = 1;
    step();
    trace_start = 0;
    step();
    reset = 1;
    step();
    checks++;
    if (path_valid !== 1'b0 || trace_busy !== 1'b0 || path_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b last=%b required 0 0 0",
               path_valid, trace_busy, path_last);
    end
    reset = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reset($urandom_range(3, 15));
      for (int k = 0; k < 25; k++) begin
        do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15), $urandom_range(0, 14));
        checks++;
        if (prev_vector_flattened !== exp_flat() || visited_vector !== exp_vis()) begin
          errors++;
          $display("FAIL rand_arrays r%0d k%0d: prev=%h vis=%h required %h %h", r, k,
                   prev_vector_flattened, visited_vector, exp_flat(), exp_vis());
        end
        checks++;
        if (unvisited_nodes !== W'(m_cnt) || all_visited !== (m_cnt == 0)) begin
          errors++;
          $display("FAIL rand_count r%0d k%0d: cnt=%0d all=%b required %0d %b", r, k,
                   unvisited_nodes, all_visited, m_cnt, m_cnt == 0);
        end
      end
      for (int t = 0; t < 4; t++) run_trace($urandom_range(0, 15), 2, "rand_trace");
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_update();
    test_trace();
    test_bad_dest();
    test_loop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/path_store.md
Name: path_store

Overview:
- Per-node visited and predecessor store for the Dijkstra datapath, parametrised in node count and index width.
- Adds two things the plain visited store does not have:
  - relaxation updates of the predecessor without marking the node visited;
  - a path-trace engine that walks predecessor pointers from a destination back to the source and streams the nodes out over a valid/ready handshake.
- Sits between the relaxation/selection control and the result output logic.

Parameters:
- MAX_NODES, 15, number of node slots; must satisfy MAX_NODES <= 2^INDEX_WIDTH - 1.
- INDEX_WIDTH, 4, width of node indices. The all-ones value is reserved as UNVISITED.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- number_of_nodes  in  INDEX_WIDTH  active node count. Sampled on reset and for range checks.
- set_en  in  1  mark set_index visited and write set_prev.
- update_en  in  1  overwrite the predecessor of set_index without changing its visited state.
- set_index  in  INDEX_WIDTH  node being written.
- set_prev  in  INDEX_WIDTH  predecessor value. The source node writes its own index.
- unvisited_nodes  out  INDEX_WIDTH  count of active nodes not yet visited.
- all_visited  out  1  high when unvisited_nodes == 0.
- visited_vector  out  MAX_NODES  bit j is the visited flag of node j.
- prev_vector_flattened  out  INDEX_WIDTH*MAX_NODES  prev[j] occupies bits [INDEX_WIDTH*j +: INDEX_WIDTH].
- trace_start  in  1  one-cycle request to trace a path. Honoured only when idle.
- trace_dest  in  INDEX_WIDTH  destination node to trace from.
- trace_busy  out  1  high while the trace FSM is not IDLE.
- trace_error  out  1  sticky error flag. Cleared by reset or by an accepted trace_start.
- path_valid  out  1  path_node is valid.
- path_ready  in  1  consumer accepts the current beat.
- path_node  out  INDEX_WIDTH  current node, emitted in order destination -> source.
- path_last  out  1  final beat of the current trace.

Behaviour:
- Reset state:
  - prev[*] = UNVISITED (all ones); visited_vector = 0.
  - unvisited_nodes = number_of_nodes.
  - FSM = IDLE; trace_busy, trace_error, path_valid and path_last = 0; path_node = 0.
  - Reset mid-trace aborts the trace immediately, with no final beat.
- Write port (registered, 1-cycle latency to outputs):
  - set_en with set_index < number_of_nodes and node not yet visited: set the visited bit, write prev = set_prev, decrement unvisited_nodes.
  - set_en on an already-visited node: no change, no decrement.
  - update_en with set_index in range and node not visited: write prev only; counter unchanged.
  - update_en on a visited node: ignored.
  - set_en and update_en in the same cycle: set_en wins.
  - set_index >= number_of_nodes: the write is ignored.
  - unvisited_nodes never wraps below 0.
- Writes are accepted while a trace is running. The trace reads the live array combinationally.
- Trace FSM states: IDLE, EMIT.
- IDLE + trace_start:
  - If trace_dest >= number_of_nodes or prev[trace_dest] == UNVISITED: set trace_error and stay in IDLE. No beats are emitted.
  - Otherwise: clear trace_error, set cur = trace_dest and steps = 0, go to EMIT on the next cycle.
- EMIT:
  - path_valid = 1 and path_node = cur.
  - path_last = 1 when any of these holds: prev[cur] == cur (source reached); prev[cur] == UNVISITED; steps == number_of_nodes - 1 (loop guard).
  - path_node and path_last are held stable while path_valid && !path_ready.
- EMIT, on path_valid && path_ready:
  - If path_last: go to IDLE. Set trace_error if the beat ended for any reason other than prev[cur] == cur.
  - Otherwise: cur <= prev[cur], steps <= steps + 1.
- Throughput: 1 beat per cycle while path_ready is held high. First beat appears 1 cycle after trace_start.
- trace_start while busy is ignored.

Test Plan:
- Reset with number_of_nodes = 5 -> unvisited_nodes = 5, all_visited = 0, every prev slot = 4'hF, visited_vector = 0.
- set (0,0), (1,0), (2,1), (3,2) -> unvisited_nodes = 1. Repeat set on node 2 with prev 3 -> prev[2] stays 1, count stays 1.
- update_en on node 4 with prev 3, then set_en on node 4 with prev 1 -> prev[4] = 1, unvisited_nodes = 0, all_visited = 1. A following update_en on node 4 leaves prev[4] = 1.
- Trace dest 3 with path_ready = 1 -> beats 3, 2, 1, 0 on consecutive cycles, path_last on node 0, trace_error = 0, trace_busy drops after the last beat.
- Same trace with path_ready toggling 1,0,0,1,... -> identical sequence, path_node held stable while stalled, no duplicated beats.
- Trace an unvisited dest, or dest = 7 with number_of_nodes = 5 -> no beats, trace_error = 1.
- Cycle prev[1] = 2, prev[2] = 1 -> exactly 5 beats emitted, then trace_error = 1.
- Reset asserted mid-trace -> path_valid = 0 and trace_busy = 0 on the next cycle.
